pc_redirect_unit: RTL and testbench

- Owns the program counter and consumes the branch target and jump address produced by the target calculators, plus register jump (jr) targets.
- Selects next PC, generates IF/ID and ID/EX flushes, and buffers one redirect that arrives while fetch is stalled.
- Sits between the ID/EX target logic and instruction memory; it is the only writer of the PC register.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/pc_redirect_unit_select.sv | 41 ++++
 rtl/pc_redirect_unit.sv | 124 ++++++++++++
 tb/tb_pc_redirect_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the PC redirect logic.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // Default PC loaded on reset.
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  // Redirect FSM: RUN fetches normally, HOLD parks one redirect during a stall.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Which request source won arbitration this cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_BR   = 2'd1,
    SEL_JR   = 2'd2,
    SEL_JMP  = 2'd3
  } sel_e;

  // Word alignment check for a candidate fetch target.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_redirect_unit_select.sv
// Priority select among branch / jr / jump requests plus alignment check.
module redirect_select
  import cpu_pkg::*;
(
  input  logic            br_taken,
  input  logic [XLEN-1:0] bta,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_addr,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_addr,
  output logic            sel_valid,
  output logic [XLEN-1:0] sel_target,
  output logic            sel_is_br,
  output logic            sel_misaligned
);

  sel_e sel;

  // The branch in EX is older than anything in ID, so it wins; jr beats jmp.
  always_comb begin
    sel = SEL_NONE;
    if (br_taken)  sel = SEL_BR;
    else if (jr)   sel = SEL_JR;
    else if (jmp)  sel = SEL_JMP;
  end

  // Route the winning target; alignment is judged on the winner only.
  always_comb begin
    sel_target = '0;
    unique case (sel)
      SEL_BR:   sel_target = bta;
      SEL_JR:   sel_target = jr_addr;
      SEL_JMP:  sel_target = jmp_addr;
      default:  sel_target = '0;
    endcase
    sel_valid      = (sel != SEL_NONE);
    sel_is_br      = (sel == SEL_BR);
    sel_misaligned = sel_valid && is_misaligned(sel_target);
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner: next-PC select, pipeline flushes, one-deep
// redirect buffer for redirects that land while fetch is stalled.
module pc_redirect_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_stall,
  input  logic             br_taken,
  input  logic [31:0]      bta,
  input  logic             jmp,
  input  logic [31:0]      jmp_addr,
  input  logic             jr,
  input  logic [31:0]      jr_addr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus_4,
  output logic             flush_if,
  output logic             flush_id,
  output logic             addr_err,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] redirect_cnt
);

  logic        sel_valid;
  logic [31:0] sel_target;
  logic        sel_is_br;
  logic        sel_misaligned;
  logic        accept;
  logic        reject;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_q, pend_d;
  logic             err_q, err_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  redirect_select u_sel (
    .br_taken       (br_taken),
    .bta            (bta),
    .jr             (jr),
    .jr_addr        (jr_addr),
    .jmp            (jmp),
    .jmp_addr       (jmp_addr),
    .sel_valid      (sel_valid),
    .sel_target     (sel_target),
    .sel_is_br      (sel_is_br),
    .sel_misaligned (sel_misaligned)
  );

  // A misaligned winner is dropped outright; lower-priority requests do not
  // get a second chance in the same cycle.
  assign accept = sel_valid && !sel_misaligned;
  assign reject = sel_valid &&  sel_misaligned;

  assign pc_plus_4 = pc_q + 32'd4;
  // flush_id only for branches: it kills the younger jump sitting in ID.
  assign flush_if  = accept;
  assign flush_id  = accept && sel_is_br;

  assign pc           = pc_q;
  assign addr_err     = err_q;
  assign err_addr     = err_addr_q;
  assign redirect_cnt = cnt_q;

  // Next-state: PC/pending-target update, error capture, redirect count.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    err_d      = reject;
    err_addr_d = reject ? sel_target : err_addr_q;
    cnt_d      = (accept && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (fetch_stall) begin
            pend_d  = sel_target;
            state_d = ST_HOLD;
          end else begin
            pc_d = sel_target;
          end
        end else if (!fetch_stall) begin
          pc_d = pc_plus_4;
        end
      end
      ST_HOLD: begin
        if (fetch_stall) begin
          // Newer redirect replaces the parked one; rejects leave it alone.
          if (accept) pend_d = sel_target;
        end else begin
          // On release a same-cycle redirect is newer than the parked one.
          pc_d    = accept ? sel_target : pend_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers; reset discards any parked redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Randomized + directed bench for pc_redirect_unit against a behavioural model.
module tb_pc_redirect_unit;

  localparam int unsigned CNT_W = 4;  // small so saturation is reached
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fetch_stall;
  logic             br_taken;
  logic [31:0]      bta;
  logic             jmp;
  logic [31:0]      jmp_addr;
  logic             jr;
  logic [31:0]      jr_addr;
  logic [31:0]      pc;
  logic [31:0]      pc_plus_4;
  logic             flush_if;
  logic             flush_id;
  logic             addr_err;
  logic [31:0]      err_addr;
  logic [CNT_W-1:0] redirect_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Model: PC, optional parked target, error pulse, saturating count.
  logic [31:0] m_pc;
  bit          m_pend_v;
  logic [31:0] m_pend;
  bit          m_err;
  logic [31:0] m_err_addr;
  int          m_cnt;

  pc_redirect_unit #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_stall  (fetch_stall),
    .br_taken     (br_taken),
    .bta          (bta),
    .jmp          (jmp),
    .jmp_addr     (jmp_addr),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .pc           (pc),
    .pc_plus_4    (pc_plus_4),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .addr_err     (addr_err),
    .err_addr     (err_addr),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, check outputs vs model, then advance
  // the model across the rising edge.
  task automatic step(input bit r, input bit st,
                      input bit b, input logic [31:0] ba,
                      input bit j, input logic [31:0] ja,
                      input bit rj, input logic [31:0] ra,
                      input bit do_chk = 1'b1);
    bit          v, ok, isbr;
    logic [31:0] t;
    @(negedge clk);
    rst_n = r; fetch_stall = st;
    br_taken = b; bta = ba; jmp = j; jmp_addr = ja; jr = rj; jr_addr = ra;
    v = b || j || rj;
    isbr = b;
    t = b ? ba : (rj ? ra : (j ? ja : 32'h0));
    ok = v && (t[1:0] == 2'b00);
    #1;
    if (do_chk) begin
      chk("pc", pc, m_pc);
      chk("pc_plus_4", pc_plus_4, m_pc + 32'd4);
      chk("flush_if", {31'b0, flush_if}, {31'b0, ok});
      chk("flush_id", {31'b0, flush_id}, {31'b0, ok && isbr});
      chk("addr_err", {31'b0, addr_err}, {31'b0, m_err});
      chk("err_addr", err_addr, m_err_addr);
      chk("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
    end
    @(posedge clk);
    if (!r) begin
      m_pc = RST_PC; m_pend_v = 0; m_pend = 0; m_err = 0; m_err_addr = 0; m_cnt = 0;
    end else begin
      m_err = v && !ok;
      if (m_err) m_err_addr = t;
      if (ok && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (!st) begin
        if (ok)            m_pc = t;
        else if (m_pend_v) m_pc = m_pend;
        else               m_pc = m_pc + 32'd4;
        m_pend_v = 0;
      end else if (ok) begin
        m_pend_v = 1; m_pend = t;
      end
    end
    #2;
  endtask

  task automatic idle(input bit st = 1'b0);
    step(1, st, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] a0, a1, a2;
    bit b, j, rj, st, r;
    m_pc = 0; m_pend_v = 0; m_pend = 0; m_err = 0; m_err_addr = 0; m_cnt = 0;
    rst_n = 0; fetch_stall = 0; br_taken = 0; bta = 0;
    jmp = 0; jmp_addr = 0; jr = 0; jr_addr = 0;

    // Reset, then free-running fetch: 0, 4, 8, C.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    idle(); chk("seq_4", pc, 32'h4);
    idle(); chk("seq_8", pc, 32'h8);
    idle(); chk("seq_c", pc, 32'hC);

    // Jump to 0x100, then jump 0x100 -> 0x400.
    step(1, 0, 0, 0, 1, 32'h100, 0, 0); chk("jmp_100", pc, 32'h100);
    step(1, 0, 0, 0, 1, 32'h400, 0, 0); chk("jmp_400", pc, 32'h400);
    chk("cnt_two", 32'(redirect_cnt), 32'd2);

    // Branch and jump together: branch wins.
    step(1, 0, 1, 32'h200, 1, 32'h400, 0, 0); chk("br_over_jmp", pc, 32'h200);

    // jr during stall, held three cycles, taken on release.
    step(1, 1, 0, 0, 0, 0, 1, 32'h80); chk("hold1", pc, 32'h200);
    idle(1);                           chk("hold2", pc, 32'h200);
    idle(1);                           chk("hold3", pc, 32'h200);
    idle(0);                           chk("rel_80", pc, 32'h80);

    // Branch mid-hold overwrites the parked jr target.
    step(1, 1, 0, 0, 0, 0, 1, 32'h80);
    step(1, 1, 1, 32'h90, 0, 0, 0, 0);
    idle(1);
    idle(0);                           chk("rel_90", pc, 32'h90);

    // Misaligned jump: ignored, one-cycle error pulse.
    step(1, 0, 0, 0, 1, 32'h402, 0, 0); chk("mis_pc", pc, 32'h94);
    chk("mis_err", {31'b0, addr_err}, 32'd1);
    chk("mis_eaddr", err_addr, 32'h402);
    idle();                            chk("mis_pulse", {31'b0, addr_err}, 32'd0);

    // Reset while holding a parked target drops it.
    step(1, 1, 0, 0, 0, 0, 1, 32'h80);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0);      chk("rst_hold", pc, RST_PC);
    idle();                            chk("rst_drop", pc, RST_PC + 32'd4);

    // PC wrap.
    step(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0); chk("wrap_pre", pc, 32'hFFFF_FFFC);
    idle();                                   chk("wrap", pc, 32'h0);

    // Random traffic, including misaligned targets and occasional resets.
    for (int i = 0; i < 800; i++) begin
      a0 = $urandom & 32'hFFFF_FFFC; if ($urandom_range(0, 5) == 0) a0[1:0] = 2'($urandom_range(1, 3));
      a1 = $urandom & 32'hFFFF_FFFC; if ($urandom_range(0, 5) == 0) a1[1:0] = 2'($urandom_range(1, 3));
      a2 = $urandom & 32'hFFFF_FFFC; if ($urandom_range(0, 5) == 0) a2[1:0] = 2'($urandom_range(1, 3));
      b  = ($urandom_range(0, 5) == 0);
      j  = ($urandom_range(0, 4) == 0);
      rj = ($urandom_range(0, 5) == 0);
      st = ($urandom_range(0, 9) < 4);
      r  = ($urandom_range(0, 149) != 0);
      step(r, st, b, a0, j, a1, rj, a2);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
